// File: rtl/temp_bus_pkg.sv
// Shared constants, FSM states and checksum helper for the single-wire temperature bus.
// Pure definitions: no latency, no backpressure.
package temp_bus_pkg;

  localparam int         FRAME_BITS      = 10;
  localparam logic [7:0] CMD_READ_TEMP   = 8'hA5;
  localparam logic [7:0] CMD_READ_STATUS = 8'h5A;
  localparam logic [15:0] TEMP_INVALID   = 16'h8000;
  localparam logic [7:0] CHK_SEED        = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_STOP,
    ST_TURN,
    ST_TX_BIT,
    ST_TX_GAP
  } state_t;

  function automatic logic [7:0] reply_chk(input logic [7:0] a, input logic [7:0] b);
    return CHK_SEED ^ a ^ b;
  endfunction

endpackage

// File: rtl/temp_frame_serializer.sv
// One 10-bit frame (start 0, data LSB first, stop 1) shifted out one bit per clock, tx registered.
// Load puts the start bit on tx next clock; done marks the stop bit; no backpressure, idles at 1.
module temp_frame_serializer
  import temp_bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       shift,
  output logic       tx,
  output logic       done
);

  logic [FRAME_BITS-1:0] shreg;
  logic [3:0]            bit_cnt;

  // Ones are shifted in behind the frame so the line rests high after the stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= '1;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= {1'b1, data, 1'b0};
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign tx   = shreg[0];
  assign done = (bit_cnt == 4'(FRAME_BITS - 1));

endmodule

// File: rtl/temp_sensor_responder.sv
// Device end of the half-duplex temperature bus: decodes 1-byte commands, replies with checksummed frames.
// cmd_valid SYNC_STAGES+10 clocks after the start bit; reply start TURNAROUND+1 clocks later; commands during a reply are lost.
module temp_sensor_responder
  import temp_bus_pkg::*;
#(
  parameter int TURNAROUND  = 4,
  parameter int BYTE_GAP    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  inout  logic        rxtx,
  input  logic [15:0] temperature,
  input  logic        temp_valid,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        frame_error,
  output logic        cmd_error,
  output logic        bus_drive,
  output logic        busy
);

  localparam logic [15:0] TURN_LAST = 16'(TURNAROUND);
  localparam logic [15:0] GAP_LAST  = (BYTE_GAP > 0) ? 16'(BYTE_GAP - 1) : 16'd0;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        rx_raw, rx_s, rx_prev;
  logic [2:0]  rx_cnt;
  logic [7:0]  rx_shift;
  logic [15:0] wait_cnt;
  logic [7:0]  rbuf [0:3];
  logic [1:0]  rlen, ridx;
  logic        is_status, fe_seen, ce_seen;
  logic        cmd_known;
  logic [15:0] t_snap;
  logic [7:0]  stat;
  logic        ser_load, ser_shift, ser_done, tx_bit, reply_done;

  // Our own transmission must never look like a start bit to the receiver.
  assign rx_raw = bus_drive | rxtx;
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign rxtx   = bus_drive ? tx_bit : 1'bz;
  assign busy   = (state != ST_IDLE);

  assign cmd_known = (rx_shift == CMD_READ_TEMP) || (rx_shift == CMD_READ_STATUS);
  assign t_snap    = temp_valid ? temperature : TEMP_INVALID;
  assign stat      = {temp_valid, fe_seen, ce_seen, 5'b0};

  always_comb begin
    state_nxt  = state;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    reply_done = 1'b0;
    case (state)
      ST_IDLE:   if (rx_prev && !rx_s) state_nxt = ST_RX;
      ST_RX:     if (rx_cnt == 3'd7) state_nxt = ST_STOP;
      ST_STOP:   state_nxt = (rx_s && cmd_known) ? ST_TURN : ST_IDLE;
      ST_TURN: begin
        if (wait_cnt == TURN_LAST) begin
          ser_load  = 1'b1;
          state_nxt = ST_TX_BIT;
        end
      end
      ST_TX_BIT: begin
        if (!ser_done) begin
          ser_shift = 1'b1;
        end else if (ridx == rlen) begin
          ser_shift  = 1'b1;
          reply_done = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (BYTE_GAP == 0) begin
          ser_load = 1'b1;
        end else begin
          ser_shift = 1'b1;
          state_nxt = ST_TX_GAP;
        end
      end
      ST_TX_GAP: begin
        if (wait_cnt == GAP_LAST) begin
          ser_load  = 1'b1;
          state_nxt = ST_TX_BIT;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      sync_q      <= '1;
      rx_prev     <= 1'b1;
      rx_cnt      <= '0;
      rx_shift    <= '0;
      wait_cnt    <= '0;
      rbuf        <= '{default: 8'h00};
      rlen        <= '0;
      ridx        <= '0;
      is_status   <= 1'b0;
      fe_seen     <= 1'b0;
      ce_seen     <= 1'b0;
      cmd_byte    <= '0;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      cmd_error   <= 1'b0;
      bus_drive   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_raw};
      rx_prev     <= rx_s;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      cmd_error   <= 1'b0;
      bus_drive   <= (state_nxt == ST_TX_BIT) || (state_nxt == ST_TX_GAP);
      wait_cnt    <= (state_nxt != state) ? 16'd0 : wait_cnt + 16'd1;

      if (state == ST_IDLE) rx_cnt <= '0;
      if (state == ST_RX) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_cnt   <= rx_cnt + 3'd1;
      end

      // Reply is snapshotted here so later input changes cannot alter it.
      if (state == ST_STOP) begin
        if (!rx_s) begin
          frame_error <= 1'b1;
          fe_seen     <= 1'b1;
        end else begin
          cmd_byte  <= rx_shift;
          cmd_valid <= 1'b1;
          ridx      <= '0;
          if (rx_shift == CMD_READ_TEMP) begin
            rbuf[0]   <= t_snap[15:8];
            rbuf[1]   <= t_snap[7:0];
            rbuf[2]   <= reply_chk(t_snap[15:8], t_snap[7:0]);
            rlen      <= 2'd3;
            is_status <= 1'b0;
          end else if (rx_shift == CMD_READ_STATUS) begin
            rbuf[0]   <= stat;
            rbuf[1]   <= reply_chk(stat, 8'h00);
            rlen      <= 2'd2;
            is_status <= 1'b1;
          end else begin
            cmd_error <= 1'b1;
            ce_seen   <= 1'b1;
          end
        end
      end

      if (ser_load) ridx <= ridx + 2'd1;
      if (reply_done && is_status) begin
        fe_seen <= 1'b0;
        ce_seen <= 1'b0;
      end
    end
  end

  temp_frame_serializer u_ser (
    .clock (clock),
    .reset (reset),
    .load  (ser_load),
    .data  (rbuf[ridx]),
    .shift (ser_shift),
    .tx    (tx_bit),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_temp_sensor_responder.sv
// Bench: host model drives command frames on two responder instances (default and fast-turnaround
// parameters) and checks pulses, turnaround, reply bytes and bus release against a reference model.
module tb_temp_sensor_responder;

  localparam int T_A = 4, G_A = 1, S_A = 2;
  localparam int T_B = 1, G_B = 0, S_B = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] temperature;
  logic        temp_valid;
  logic        host_oe, host_tx;
  int          sel;

  wire rxtx_a, rxtx_b;
  assign rxtx_a = (host_oe && sel == 0) ? host_tx : 1'bz;
  assign rxtx_b = (host_oe && sel == 1) ? host_tx : 1'bz;
  pullup (rxtx_a);
  pullup (rxtx_b);

  logic [7:0] cmd_byte_a, cmd_byte_b;
  logic cmd_valid_a, cmd_valid_b, frame_error_a, frame_error_b, cmd_error_a, cmd_error_b;
  logic bus_drive_a, bus_drive_b, busy_a, busy_b;

  temp_sensor_responder #(.TURNAROUND(T_A), .BYTE_GAP(G_A), .SYNC_STAGES(S_A)) dut_a (
    .clock(clock), .reset(reset), .rxtx(rxtx_a), .temperature(temperature), .temp_valid(temp_valid),
    .cmd_byte(cmd_byte_a), .cmd_valid(cmd_valid_a), .frame_error(frame_error_a),
    .cmd_error(cmd_error_a), .bus_drive(bus_drive_a), .busy(busy_a));

  temp_sensor_responder #(.TURNAROUND(T_B), .BYTE_GAP(G_B), .SYNC_STAGES(S_B)) dut_b (
    .clock(clock), .reset(reset), .rxtx(rxtx_b), .temperature(temperature), .temp_valid(temp_valid),
    .cmd_byte(cmd_byte_b), .cmd_valid(cmd_valid_b), .frame_error(frame_error_b),
    .cmd_error(cmd_error_b), .bus_drive(bus_drive_b), .busy(busy_b));

  wire       line          = (sel == 1) ? rxtx_b : rxtx_a;
  wire [7:0] o_cmd_byte    = (sel == 1) ? cmd_byte_b : cmd_byte_a;
  wire       o_cmd_valid   = (sel == 1) ? cmd_valid_b : cmd_valid_a;
  wire       o_frame_error = (sel == 1) ? frame_error_b : frame_error_a;
  wire       o_cmd_error   = (sel == 1) ? cmd_error_b : cmd_error_a;
  wire       o_bus_drive   = (sel == 1) ? bus_drive_b : bus_drive_a;
  wire       o_busy        = (sel == 1) ? busy_b : busy_a;

  always #5 clock = ~clock;

  int checks = 0, passes = 0, fails = 0;
  bit fe_seen [2];
  bit ce_seen [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_cmd(input logic [7:0] code, input bit good_stop, input bit chg_temp,
                        input int abort_byte);
    logic [7:0]  exp_q [$];
    logic [15:0] t;
    logic [7:0]  x;
    logic [9:0]  fr, tx_fr;
    int          lat, tn, gp, ss;
    bit          known, is_stat, seen, busy_before, drv_ok, gap_ok, quiet;
    tn = (sel == 1) ? T_B : T_A;
    gp = (sel == 1) ? G_B : G_A;
    ss = (sel == 1) ? S_B : S_A;
    known   = good_stop && (code == 8'hA5 || code == 8'h5A);
    is_stat = good_stop && (code == 8'h5A);
    exp_q = {};
    if (known && !is_stat) begin
      t = temp_valid ? temperature : 16'h8000;
      exp_q.push_back(t[15:8]);
      exp_q.push_back(t[7:0]);
    end else if (is_stat) begin
      exp_q.push_back({temp_valid, fe_seen[sel], ce_seen[sel], 5'b0});
    end
    x = 8'hFF;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    if (known) exp_q.push_back(x);

    tx_fr = {good_stop, code, 1'b0};
    for (int k = 0; k < 10; k++) begin
      step();
      host_oe = 1'b1;
      host_tx = tx_fr[k];
    end
    step();
    host_oe = 1'b0;
    lat = 10;
    seen = 1'b0;
    busy_before = 1'b0;
    while (!seen && lat < 40) begin
      if (o_cmd_valid || o_frame_error) seen = 1'b1;
      else begin
        if (lat == 9 + ss) busy_before = o_busy;
        step();
        lat++;
      end
    end
    chk("pulse_latency", lat, 10 + ss);
    chk("frame_error", 32'(o_frame_error), 32'(!good_stop));
    chk("cmd_valid", 32'(o_cmd_valid), 32'(good_stop));
    chk("cmd_error", 32'(o_cmd_error), 32'(good_stop && !known));
    if (good_stop) chk("cmd_byte", 32'(o_cmd_byte), 32'(code));
    chk("busy_before_pulse", 32'(busy_before), 32'd1);
    chk("busy_at_pulse", 32'(o_busy), 32'(known));
    if (!good_stop) fe_seen[sel] = 1'b1;
    else if (!known) ce_seen[sel] = 1'b1;

    step();
    lat = 1;
    chk("pulse_width", 32'(o_cmd_valid | o_frame_error | o_cmd_error), 32'd0);
    if (!known) begin
      quiet = 1'b1;
      for (int i = 0; i < tn + 3; i++) begin
        step();
        quiet = quiet & ~o_bus_drive & line;
      end
      chk("no_reply", 32'(quiet), 32'd1);
      chk("idle_busy", 32'(o_busy), 32'd0);
      return;
    end

    while (!(o_bus_drive && !line) && lat < 40) begin
      step();
      lat++;
    end
    chk("turnaround", lat, tn + 1);
    drv_ok = 1'b1;
    gap_ok = 1'b1;
    for (int b = 0; b < exp_q.size(); b++) begin
      if (b > 0) begin
        for (int g = 0; g < gp; g++) begin
          step();
          gap_ok = gap_ok & o_bus_drive & line;
        end
        step();
      end
      for (int k = 0; k < 10; k++) begin
        if (k > 0) step();
        fr[k] = line;
        drv_ok = drv_ok & o_bus_drive;
        if (b == abort_byte && k == 4) begin
          reset = 1'b1;
          step();
          chk("reset_drive", 32'(o_bus_drive), 32'd0);
          chk("reset_busy", 32'(o_busy), 32'd0);
          chk("reset_line", 32'(line), 32'd1);
          reset = 1'b0;
          fe_seen = '{1'b0, 1'b0};
          ce_seen = '{1'b0, 1'b0};
          return;
        end
      end
      chk("reply_byte", 32'(fr[8:1]), 32'(exp_q[b]));
      chk("reply_framing", 32'({fr[9], fr[0]}), 32'd2);
      if (b == 0 && chg_temp) temperature = 16'h7FFF;
    end
    chk("reply_drive", 32'(drv_ok), 32'd1);
    chk("reply_gap", 32'(gap_ok), 32'd1);
    step();
    chk("release_drive", 32'(o_bus_drive), 32'd0);
    chk("release_busy", 32'(o_busy), 32'd0);
    if (is_stat) begin
      fe_seen[sel] = 1'b0;
      ce_seen[sel] = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] code;
    int         r;
    reset = 1'b1;
    host_oe = 1'b0;
    host_tx = 1'b1;
    sel = 0;
    temperature = 16'h0190;
    temp_valid = 1'b1;
    fe_seen = '{1'b0, 1'b0};
    ce_seen = '{1'b0, 1'b0};
    repeat (3) step();
    chk("rst_outputs_a", 32'({cmd_byte_a, cmd_valid_a, frame_error_a, cmd_error_a, bus_drive_a, busy_a}), 32'd0);
    chk("rst_outputs_b", 32'({cmd_byte_b, cmd_valid_b, frame_error_b, cmd_error_b, bus_drive_b, busy_b}), 32'd0);
    chk("rst_line_a", 32'(rxtx_a), 32'd1);
    reset = 1'b0;
    repeat (3) step();

    do_cmd(8'hA5, 1'b1, 1'b0, -1);
    do_cmd(8'h3C, 1'b0, 1'b0, -1);
    do_cmd(8'h5A, 1'b1, 1'b0, -1);
    do_cmd(8'h5A, 1'b1, 1'b0, -1);
    do_cmd(8'h00, 1'b1, 1'b0, -1);
    do_cmd(8'hA5, 1'b1, 1'b1, -1);
    temperature = 16'h0190;
    do_cmd(8'hA5, 1'b1, 1'b0, 1);
    repeat (3) step();
    do_cmd(8'hA5, 1'b1, 1'b0, -1);
    temp_valid = 1'b0;
    do_cmd(8'hA5, 1'b1, 1'b0, -1);
    sel = 1;
    repeat (3) step();
    do_cmd(8'hA5, 1'b1, 1'b0, -1);
    temp_valid = 1'b1;
    do_cmd(8'hA5, 1'b1, 1'b0, -1);
    do_cmd(8'h5A, 1'b1, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 1));
      temperature = 16'($urandom);
      temp_valid = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 5));
      if (r < 2) code = 8'hA5;
      else if (r < 4) code = 8'h5A;
      else begin
        code = 8'($urandom);
        while (code == 8'hA5 || code == 8'h5A) code = 8'($urandom);
      end
      repeat (int'($urandom_range(1, 4))) step();
      do_cmd(code, r != 5, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
